// File: rtl/jt6295_pkg.sv
// Shared constants, tables and types for the jt6295 ADPCM decoder.
// Optional feature macro: JT6295_ADPCM_SAT_EN (saturate decoded signal instead of wrapping).
package jt6295_pkg;

   localparam int unsigned SW      = 12;  // sample width
   localparam int unsigned IDXW    = 6;   // step-index width
   localparam int unsigned STEPW   = 11;  // step-table entry width
   localparam int unsigned CHN     = 4;   // channels per frame
   localparam int unsigned CHW     = 2;   // channel index width
   localparam int unsigned NIBW    = 4;   // ADPCM code width
   localparam int unsigned ATTW    = 4;   // attenuation code width
   localparam int unsigned VOLW    = 6;   // volume multiplier width
   localparam int unsigned ADJW    = 5;   // index adjust width (+8 needs 5 signed bits)
   localparam int unsigned DIFFW   = 13;  // delta magnitude width
   localparam int unsigned ACCW    = 14;  // signal + delta width
   localparam int unsigned PRODW   = 18;  // attenuation product width
   localparam int unsigned STEP_N  = 49;
   localparam int unsigned VOL_N   = 9;

   localparam logic [IDXW-1:0] IDX_MAX = IDXW'(48);

   localparam logic [STEPW-1:0] STEP_TBL [STEP_N] = '{
      11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
      11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
      11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
      11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
      11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
      11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
      11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
   };

   localparam logic signed [ADJW-1:0] ADJ [8] = '{
      -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
   };

   localparam logic [VOLW-1:0] VOL_TBL [VOL_N] = '{
      6'd32, 6'd22, 6'd16, 6'd11, 6'd8, 6'd6, 6'd4, 6'd3, 6'd2
   };

   // Stage-1 to stage-2 payload
   typedef struct packed {
      logic signed [SW-1:0]   sig;
      logic        [ATTW-1:0] att;
   } s1_t;

   // Attenuation codes past the table mute the channel
   function automatic logic [VOLW-1:0] vol_of(input logic [ATTW-1:0] att);
      if (att < ATTW'(VOL_N)) return VOL_TBL[att];
      else                    return '0;
   endfunction

endpackage

// File: rtl/jt6295_adpcm_step.sv
// One OKI ADPCM decode step: (signal, index, nibble) -> (next signal, next index).
// Optional feature macro: JT6295_ADPCM_SAT_EN (saturate instead of wrap).
module jt6295_adpcm_step
   import jt6295_pkg::*;
(
   input  logic signed [SW-1:0]   sig_i,
   input  logic        [IDXW-1:0] idx_i,
   input  logic        [NIBW-1:0] nib_i,
   output logic signed [SW-1:0]   sig_o,
   output logic        [IDXW-1:0] idx_o
);

   localparam logic signed [ACCW-1:0] ACC_MAX = 14'sd2047;
   localparam logic signed [ACCW-1:0] ACC_MIN = -14'sd2048;

   logic        [STEPW-1:0]  step;
   logic        [DIFFW-1:0]  diff;
   logic signed [ACCW-1:0]   acc;
   logic signed [IDXW+1:0]   idx_s;

   // Delta from step magnitude bits, then signed accumulate and index adjust
   always_comb begin
      step = STEP_TBL[idx_i];
      diff = DIFFW'(step >> 3)
           + (nib_i[2] ? DIFFW'(step)      : '0)
           + (nib_i[1] ? DIFFW'(step >> 1) : '0)
           + (nib_i[0] ? DIFFW'(step >> 2) : '0);

      if (nib_i[3]) acc = ACCW'(sig_i) - $signed(ACCW'(diff));
      else          acc = ACCW'(sig_i) + $signed(ACCW'(diff));

`ifdef JT6295_ADPCM_SAT_EN
      if (acc > ACC_MAX)      sig_o = 12'sd2047;
      else if (acc < ACC_MIN) sig_o = -12'sd2048;
      else                    sig_o = acc[SW-1:0];
`else
      sig_o = acc[SW-1:0];
`endif

      idx_s = $signed({2'b00, idx_i}) + (IDXW+2)'(ADJ[nib_i[2:0]]);
      if (idx_s < 8'sd0)                        idx_o = '0;
      else if (idx_s > $signed({2'b00, IDX_MAX})) idx_o = IDX_MAX;
      else                                      idx_o = idx_s[IDXW-1:0];
   end

endmodule

// File: rtl/jt6295_adpcm_dec.sv
// Four-slot time-multiplexed OKI ADPCM decoder with per-slot attenuation.
// Optional feature macro: JT6295_ADPCM_SAT_EN (handled in jt6295_adpcm_step).
module jt6295_adpcm_dec
   import jt6295_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cen,
   input  logic                 cen4,
   input  logic                 start,
   input  logic                 en,
   input  logic                 nib_vld,
   input  logic [NIBW-1:0]      nib,
   input  logic [ATTW-1:0]      att,
   output logic [CHW-1:0]       ch,
   output logic signed [SW-1:0] sound_out
);

   logic        [CHW-1:0]  ch_q, ch_d;
   logic signed [SW-1:0]   snd_q, snd_d;
   s1_t                    s1_q, s1_d;
   logic signed [SW-1:0]   sig_q [CHN];
   logic        [IDXW-1:0] idx_q [CHN];

   logic        [CHW-1:0]  slot_c;
   logic signed [SW-1:0]   cur_sig, step_sig, sig_d;
   logic        [IDXW-1:0] cur_idx, step_idx, idx_d;
   logic                   upd;
   logic signed [PRODW-1:0] prod;

   assign slot_c  = cen ? '0 : ch_q;
   assign cur_sig = sig_q[slot_c];
   assign cur_idx = idx_q[slot_c];

   jt6295_adpcm_step u_step (
      .sig_i (cur_sig),
      .idx_i (cur_idx),
      .nib_i (nib),
      .sig_o (step_sig),
      .idx_o (step_idx)
   );

   // Next-state: slot counter, channel state update, two pipeline stages
   always_comb begin
      ch_d  = ch_q;
      s1_d  = s1_q;
      snd_d = snd_q;
      sig_d = cur_sig;
      idx_d = cur_idx;
      upd   = 1'b0;
      prod  = $signed(PRODW'(s1_q.sig)) * $signed(PRODW'(vol_of(s1_q.att)));
      if (cen4) begin
         ch_d     = cen ? CHW'(1) : ch_q + CHW'(1);
         snd_d    = prod[SW+4:5];
         s1_d.att = att;
         s1_d.sig = '0;
         if (start) begin
            upd   = 1'b1;
            sig_d = '0;
            idx_d = '0;
         end else if (en && nib_vld) begin
            upd      = 1'b1;
            sig_d    = step_sig;
            idx_d    = step_idx;
            s1_d.sig = step_sig;
         end else if (en) begin
            s1_d.sig = cur_sig;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ch_q  <= '0;
         snd_q <= '0;
         s1_q  <= '0;
         for (int i = 0; i < CHN; i++) begin
            sig_q[i] <= '0;
            idx_q[i] <= '0;
         end
      end else begin
         ch_q  <= ch_d;
         snd_q <= snd_d;
         s1_q  <= s1_d;
         if (upd) begin
            sig_q[slot_c] <= sig_d;
            idx_q[slot_c] <= idx_d;
         end
      end
   end

   assign ch        = ch_q;
   assign sound_out = snd_q;

endmodule
